// File: rtl/cond_branch_unit.sv
// Conditional branch unit: captures a Bcond/Jcond request, waits out pending flag writes,
// evaluates the condition against {C,L,F,Z,N} and returns taken + next PC.
// Optional build macro BRANCH_STATS_EN adds saturating taken/not-taken counters.
module cond_branch_unit #(
    parameter int ADDR_W = 16,
    parameter int DISP_W = 8,
    parameter int PC_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic              br_kind,
    input  logic [DISP_W-1:0] br_disp,
    input  logic [ADDR_W-1:0] br_reg,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [4:0]        flags_clfzn,
    input  logic              flag_write_pend,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       nottaken_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2,
        RESP       = 2'd3
    } state_t;

    state_t state, nextState;

    logic [3:0]        capCond;
    logic              capKind;
    logic [DISP_W-1:0] capDisp;
    logic [ADDR_W-1:0] capReg;
    logic [ADDR_W-1:0] capPc;

    logic              accept;
    logic              condTrue;
    logic [ADDR_W-1:0] nextTarget;

    assign accept = br_valid && br_ready;

    // Flag bit positions: C=4, L=3, F=2, Z=1, N=0.
    function automatic logic evalCond(input logic [3:0] cond, input logic [4:0] f);
        logic c, l, fl, z, n, r;
        {c, l, fl, z, n} = f;
        r = 1'b0;
        case (cond)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = c;
            4'h3: r = !c;
            4'h4: r = l;
            4'h5: r = !l;
            4'h6: r = n;
            4'h7: r = !n;
            4'h8: r = fl;
            4'h9: r = !fl;
            4'hA: r = !l && !z;
            4'hB: r = l || z;
            4'hC: r = !n && !z;
            4'hD: r = n || z;
            4'hE: r = 1'b1;
            4'hF: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (accept) nextState = flag_write_pend ? WAIT_FLAGS : EVAL;
            WAIT_FLAGS: if (!flag_write_pend) nextState = EVAL;
            EVAL:       nextState = RESP;
            RESP:       if (res_ready) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    always_comb begin
        br_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE:    br_ready  = 1'b1;
            RESP:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capCond <= '0;
            capKind <= 1'b0;
            capDisp <= '0;
            capReg  <= '0;
            capPc   <= '0;
        end else if (accept) begin
            capCond <= br_cond;
            capKind <= br_kind;
            capDisp <= br_disp;
            capReg  <= br_reg;
            capPc   <= pc_in;
        end
    end

    // Flags are sampled only in EVAL, after any pending write has landed.
    assign condTrue = evalCond(capCond, flags_clfzn);

    always_comb begin
        nextTarget = capPc + ADDR_W'(PC_INC);
        if (condTrue) begin
            if (capKind) nextTarget = capReg;
            else         nextTarget = capPc + {{(ADDR_W-DISP_W){capDisp[DISP_W-1]}}, capDisp};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_taken  <= 1'b0;
            res_target <= '0;
        end else if (state == EVAL) begin
            res_taken  <= condTrue;
            res_target <= nextTarget;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (res_valid && res_ready) begin
            if (res_taken && taken_cnt != 16'hFFFF)         taken_cnt    <= taken_cnt + 16'd1;
            if (!res_taken && nottaken_cnt != 16'hFFFF)     nottaken_cnt <= nottaken_cnt + 16'd1;
        end
    end
`endif

endmodule
